multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath (pc, register_file, alu, shared instruction/data memory).

---
 rtl/multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle sequencer for an RV32I datapath (pc, register file, alu and a
//   shared instruction/data memory). Each instruction walks through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK). The block decodes
//   opcode/funct3/funct7 into alu_op and the datapath enables. It also runs the
//   memory handshake and raises a sticky trap on an illegal opcode or on a
//   memory timeout.
//
//   Optional feature (compile-time macro CTRL_RETIRE_CNT_EN):
//     Adds a retired-instruction counter (o_retired) with a clear input
//     (i_retired_clr). When the macro is undefined, neither port nor any
//     counter logic exists.
//
// Parameters
//   MEM_TIMEOUT  Maximum number of cycles mem_req may wait for mem_ready before
//                the sequencer traps (>= 1).
//   CNT_W        Width of the retired-instruction counter.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         synchronous reset, active low
//   i_instruction   IR contents (valid from DECODE onward)
//   i_alu_zero      alu result == 0 (valid in EXECUTE)
//   i_mem_ready     memory accepts/completes the current access this cycle
//   o_mem_req       memory access request
//   o_mem_we        store request (only with o_mem_req)
//   o_mem_addr_sel  memory address source: 0 = pc, 1 = alu result
//   o_ir_write      load IR from memory read data
//   o_pc_write      pc <= pc + 4
//   o_pc_branch     pc <= branch target
//   o_reg_write     register file write enable
//   o_wb_sel_mem    write-back source: 1 = memory data, 0 = alu result
//   o_alu_src_imm   alu operand b = sign-extended immediate
//   o_alu_op        ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7
//   o_trap          sticky fault flag
//   i_retired_clr   (CTRL_RETIRE_CNT_EN) clear the retired counter
//   o_retired       (CTRL_RETIRE_CNT_EN) retired-instruction count
//
// State table
//   state       | meaning
//   S_FETCH     | read instruction at pc; wait for mem_ready
//   S_DECODE    | register operands settle; classify the instruction
//   S_EXECUTE   | alu operates; branches resolve here
//   S_MEM       | load/store access at the alu address; wait for mem_ready
//   S_WRITEBACK | register file write (alu result or load data)
//   S_TRAP      | fault; all outputs low except trap; left only by reset
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instruction,
  input  logic        i_alu_zero,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_pc_branch,
  output logic        o_reg_write,
  output logic        o_wb_sel_mem,
  output logic        o_alu_src_imm,
  output logic [2:0]  o_alu_op,
  output logic        o_trap
`ifdef CTRL_RETIRE_CNT_EN
  ,
  input  logic             i_retired_clr,
  output logic [CNT_W-1:0] o_retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_ILL    = 3'd5
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  cls_t              r_cls;
  logic [2:0]        r_alu_op;
  logic              r_alu_imm;
  logic              r_bne;
  logic [WAIT_W-1:0] r_wait;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  cls_t       w_cls;
  logic [2:0] w_alu_op;
  logic       w_alu_imm;
  logic       w_access;
  logic       w_timeout;
  logic       w_unused_bits;

  assign w_opcode      = i_instruction[6:0];
  assign w_f3          = i_instruction[14:12];
  assign w_unused_bits = ^{i_instruction[31], i_instruction[29:15], i_instruction[11:7]};

  // Instruction classification and alu operation. SLTU/SLTIU (f3=011) and
  // non-word loads/stores are not supported and classify as illegal.
  always_comb begin
    w_cls    = C_ILL;
    w_alu_op = ALU_ADD;
    unique case (w_opcode)
      OP_R:      if (w_f3 != 3'b011) w_cls = C_R;
      OP_I:      if (w_f3 != 3'b011) w_cls = C_I;
      OP_LOAD:   if (w_f3 == 3'b010) w_cls = C_LOAD;
      OP_STORE:  if (w_f3 == 3'b010) w_cls = C_STORE;
      OP_BRANCH: if (w_f3[2:1] == 2'b00) w_cls = C_BRANCH;
      default:   w_cls = C_ILL;
    endcase
    case (w_f3)
      3'b000:  w_alu_op = (w_opcode == OP_R && i_instruction[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
    if (w_cls == C_LOAD || w_cls == C_STORE) w_alu_op = ALU_ADD;
    if (w_cls == C_BRANCH)                   w_alu_op = ALU_SUB;
  end

  assign w_alu_imm = (w_cls == C_I) || (w_cls == C_LOAD) || (w_cls == C_STORE);

  // The final permitted wait cycle with mem_ready still low sends us to TRAP;
  // mem_ready in that same cycle completes the access instead.
  assign w_access  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout = w_access && !i_mem_ready && (r_wait == WAIT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_cls     <= C_R;
      r_alu_op  <= ALU_ADD;
      r_alu_imm <= 1'b0;
      r_bne     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_mem_ready) begin
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else begin
            r_wait  <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_cls     <= w_cls;
          r_alu_op  <= w_alu_op;
          r_alu_imm <= w_alu_imm;
          r_bne     <= w_f3[0];
          r_state   <= (w_cls == C_ILL) ? S_TRAP : S_EXECUTE;
        end
        S_EXECUTE: begin
          if (r_cls == C_BRANCH)                         r_state <= S_FETCH;
          else if (r_cls == C_LOAD || r_cls == C_STORE)  r_state <= S_MEM;
          else                                           r_state <= S_WRITEBACK;
        end
        S_MEM: begin
          if (i_mem_ready) begin
            r_state <= (r_cls == C_STORE) ? S_FETCH : S_WRITEBACK;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else begin
            r_wait  <= r_wait + WAIT_W'(1);
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_TRAP;
      endcase
    end
  end

  // Outputs are decoded from the registered state. The handshake and branch
  // strobes also depend on this cycle's mem_ready/alu_zero, and everything is
  // held low while reset is asserted so an access in flight drops at once.
  // alu_op/alu_src_imm stay valid from EXECUTE through WRITEBACK so the alu
  // result (memory address or write-back value) remains stable.
  always_comb begin
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_branch    = 1'b0;
    o_reg_write    = 1'b0;
    o_wb_sel_mem   = 1'b0;
    o_alu_src_imm  = 1'b0;
    o_alu_op       = ALU_ADD;
    o_trap         = 1'b0;
    if (i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req  = 1'b1;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
        end
        S_EXECUTE: begin
          o_alu_op      = r_alu_op;
          o_alu_src_imm = r_alu_imm;
          o_pc_branch   = (r_cls == C_BRANCH) && (r_bne ? !i_alu_zero : i_alu_zero);
        end
        S_MEM: begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = 1'b1;
          o_mem_we       = (r_cls == C_STORE);
          o_alu_op       = r_alu_op;
          o_alu_src_imm  = r_alu_imm;
        end
        S_WRITEBACK: begin
          o_reg_write   = 1'b1;
          o_wb_sel_mem  = (r_cls == C_LOAD);
          o_alu_op      = r_alu_op;
          o_alu_src_imm = r_alu_imm;
        end
        S_TRAP:  o_trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  assign w_retire = (r_state == S_WRITEBACK)
                 || (r_state == S_MEM && i_mem_ready && r_cls == C_STORE)
                 || (r_state == S_EXECUTE && r_cls == C_BRANCH);

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_retired_clr) r_retired <= '0;
    else if (w_retire)             r_retired <= r_retired + CNT_W'(1);
  end

  assign o_retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  typedef logic [12:0] vec_t;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_instruction;
  logic        i_alu_zero;
  logic        i_mem_ready;
  logic        i_retired_clr;
  logic        o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_write, o_pc_write;
  logic        o_pc_branch, o_reg_write, o_wb_sel_mem, o_alu_src_imm, o_trap;
  logic [2:0]  o_alu_op;
`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] o_retired;
`endif

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_instruction  (i_instruction),
    .i_alu_zero     (i_alu_zero),
    .i_mem_ready    (i_mem_ready),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr_sel (o_mem_addr_sel),
    .o_ir_write     (o_ir_write),
    .o_pc_write     (o_pc_write),
    .o_pc_branch    (o_pc_branch),
    .o_reg_write    (o_reg_write),
    .o_wb_sel_mem   (o_wb_sel_mem),
    .o_alu_src_imm  (o_alu_src_imm),
    .o_alu_op       (o_alu_op),
    .o_trap         (o_trap)
`ifdef CTRL_RETIRE_CNT_EN
    ,
    .i_retired_clr  (i_retired_clr),
    .o_retired      (o_retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  vec_t  exp_q[$];
  string tag_q[$];
  logic [2:0] alu_by_f3 [8];
  int exp_retired = 0;
  bit clr_wb = 0;

  // {trap, req, we, addr_sel, ir_write, pc_write, pc_branch, reg_write, wb_sel_mem, src_imm, alu_op}
  function automatic vec_t v(bit trap, bit req, bit we, bit asel, bit irw, bit pcw,
                             bit pcb, bit rw, bit wbm, bit imm, logic [2:0] aop);
    return {trap, req, we, asel, irw, pcw, pcb, rw, wbm, imm, aop};
  endfunction

  wire vec_t w_act = {o_trap, o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_write, o_pc_write,
                      o_pc_branch, o_reg_write, o_wb_sel_mem, o_alu_src_imm, o_alu_op};

  // Monitor: one expected output vector per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL %s t=%0t actual=%b required=%b", t, $time, w_act, e);
      end
      checks++;
      if ((o_pc_write && o_pc_branch) || (o_reg_write && o_ir_write) ||
          (o_pc_branch && o_reg_write)) begin
        errors++;
        $display("FAIL pulse_overlap t=%0t actual=%b required=no overlapping pulses", $time, w_act);
      end
    end
  end

  task automatic cyc(input bit rdy, input bit z, input vec_t e, input string tag);
    i_mem_ready = rdy;
    i_alu_zero  = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    i_reset = 1'b0;
    for (int i = 0; i < n; i++) cyc(rb(), rb(), '0, "reset_outputs");
    i_reset = 1'b1;
    exp_retired = 0;
  endtask

  // Reference: instruction legality from the supported opcode list.
  function automatic bit legal(logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'b0110011 || op == 7'b0010011) return f3 != 3'd3;
    if (op == 7'b0000011 || op == 7'b0100011) return f3 == 3'd2;
    if (op == 7'b1100011) return f3 <= 3'd1;
    return 0;
  endfunction

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) cyc(rb(), rb(), v(1,0,0,0,0,0,0,0,0,0,0), "trap_sticky");
    do_reset(1 + $urandom_range(0, 1));
  endtask

  // Drive one instruction; fw/mw are wait cycles before mem_ready in FETCH/MEM,
  // abort >= 0 stops inside MEM after that many wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input bit z, input int abort, output bit trapped);
    logic [6:0] op;
    logic [2:0] f3, aop;
    bit is_ld, is_st, is_br, imm;
    int k;
    trapped = 0;
    op = ins[6:0];
    f3 = ins[14:12];
    i_instruction = ins;
    k = 0;
    while (1) begin
      if (k == fw) begin
        cyc(1, rb(), v(0,1,0,0,1,1,0,0,0,0,0), "fetch_done");
        break;
      end
      cyc(0, rb(), v(0,1,0,0,0,0,0,0,0,0,0), "fetch_wait");
      if (k == TO - 1) begin trapped = 1; return; end
      k++;
    end
    cyc(rb(), rb(), '0, "decode");
    if (!legal(ins)) begin trapped = 1; return; end
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    is_br = (op == 7'b1100011);
    imm   = is_ld || is_st || (op == 7'b0010011);
    if (is_ld || is_st) aop = 3'd0;
    else if (is_br)     aop = 3'd1;
    else if (op == 7'b0110011 && f3 == 3'd0 && ins[30]) aop = 3'd1;
    else aop = alu_by_f3[f3];
    if (is_br) begin
      cyc(rb(), z, v(0,0,0,0,0,0,(f3 == 3'd0) ? z : !z,0,0,0,aop), "exec_branch");
      exp_retired++;
      return;
    end
    cyc(rb(), rb(), v(0,0,0,0,0,0,0,0,0,imm,aop), "execute");
    if (is_ld || is_st) begin
      k = 0;
      while (1) begin
        if (k == abort) return;
        if (k == mw) begin
          cyc(1, rb(), v(0,1,is_st,1,0,0,0,0,0,imm,aop), "mem_done");
          break;
        end
        cyc(0, rb(), v(0,1,is_st,1,0,0,0,0,0,imm,aop), "mem_wait");
        if (k == TO - 1) begin trapped = 1; return; end
        k++;
      end
      if (is_st) begin exp_retired++; return; end
    end
    i_retired_clr = clr_wb;
    cyc(rb(), rb(), v(0,0,0,0,0,0,0,1,is_ld,imm,aop), "writeback");
    i_retired_clr = 1'b0;
    if (clr_wb) exp_retired = 0;
    else        exp_retired++;
  endtask

  task automatic go(input logic [31:0] ins, input int fw, input int mw, input bit z);
    bit t;
    run_instr(ins, fw, mw, z, -1, t);
    if (t) trap_tail();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: r[6:0] = 7'b0110011;
      2, 3: r[6:0] = 7'b0010011;
      4: begin r[6:0] = 7'b0000011; if ($urandom_range(0, 7) != 0) r[14:12] = 3'd2; end
      5: begin r[6:0] = 7'b0100011; if ($urandom_range(0, 7) != 0) r[14:12] = 3'd2; end
      6, 7: begin r[6:0] = 7'b1100011; if ($urandom_range(0, 7) != 0) r[14:12] = 3'($urandom_range(0, 1)); end
      default: ;
    endcase
    return r;
  endfunction

  function automatic int rand_wait();
    int s;
    s = $urandom_range(0, 39);
    if (s == 0) return TO;
    if (s == 1) return TO - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=bench completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit t;
    alu_by_f3[0] = 3'd0; alu_by_f3[1] = 3'd5; alu_by_f3[2] = 3'd7; alu_by_f3[3] = 3'd0;
    alu_by_f3[4] = 3'd4; alu_by_f3[5] = 3'd6; alu_by_f3[6] = 3'd3; alu_by_f3[7] = 3'd2;
    i_reset = 1'b0; i_instruction = '0; i_alu_zero = 1'b0; i_mem_ready = 1'b0;
    i_retired_clr = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    go(32'h005303b3, 0, 0, 0);          // add x7,x6,x5
    go(32'h40848533, 3, 0, 0);          // sub, fetch waits 3
    go(32'h00432283, 0, 0, 0);          // lw x5,4(x6)
    go(32'h00532423, 0, 0, 0);          // sw x5,8(x6)
    go(32'h00432283, 2, 5, 0);          // lw with waits
    go(32'h00000063, 0, 0, 1);          // beq taken
    go(32'h00000063, 0, 0, 0);          // beq not taken
    go(32'h00001063, 0, 0, 1);          // bne not taken
    go(32'h00001063, 0, 0, 0);          // bne taken
    go(32'h005303b3, TO - 1, 0, 0);     // last permitted wait cycle completes
    go(32'h00532423, 0, TO - 1, 0);     // same boundary in MEM
    go(32'h00000000, 0, 0, 0);          // illegal opcode
    go(32'h00003033, 0, 0, 0);          // sltu: illegal
    go(32'h005303b3, TO, 0, 0);         // fetch timeout
    go(32'h00432283, 0, TO, 0);         // mem timeout

    run_instr(32'h00432283, 0, 10, 0, 2, t);   // reset mid-MEM
    do_reset(1);
    go(32'h005303b3, 0, 0, 0);

`ifdef CTRL_RETIRE_CNT_EN
    checks++;
    if (o_retired !== CNT_W'(exp_retired)) begin
      errors++;
      $display("FAIL retired_count actual=%0d required=%0d", o_retired, exp_retired);
    end
    clr_wb = 1;
    go(32'h005303b3, 0, 0, 0);
    clr_wb = 0;
    checks++;
    if (o_retired !== '0) begin
      errors++;
      $display("FAIL retired_clr actual=%0d required=0", o_retired);
    end
`endif

    for (int n = 0; n < 300; n++) go(rand_ins(), rand_wait(), rand_wait(), rb());

`ifdef CTRL_RETIRE_CNT_EN
    checks++;
    if (o_retired !== CNT_W'(exp_retired)) begin
      errors++;
      $display("FAIL retired_final actual=%0d required=%0d", o_retired, exp_retired);
    end
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
